// File: rtl/mod_arith_pkg.sv
// Shared types and constants for the modular-arithmetic datapath.
// The err payload bits exist only when MOD_SUB_RANGE_CHK_EN is defined.
package mod_arith_pkg;

  localparam int MOD_BIT_SIZE    = 60;
  localparam int MOD_SUB_LATENCY = 2;

  typedef struct packed {
`ifdef MOD_SUB_RANGE_CHK_EN
    logic                    err;
`endif
    logic                    borrow;
    logic [MOD_BIT_SIZE-1:0] diff;
    logic [MOD_BIT_SIZE-1:0] q;
  } sub_s1_t;

  typedef struct packed {
`ifdef MOD_SUB_RANGE_CHK_EN
    logic                    err;
`endif
    logic [MOD_BIT_SIZE-1:0] m;
  } sub_s2_t;

endpackage

// File: rtl/mod_pipe_slice.sv
// Generic valid/ready register slice with async active-low reset.
// Data is only loaded on a real transfer, so it holds through bubbles.
module mod_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_adv;

  assign w_adv   = !r_valid | i_ready;
  assign o_ready = w_adv;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_adv) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/mod_sub_pipe.sv
// Two-stage pipelined modular subtractor M = (A - B) mod q.
// Define MOD_SUB_RANGE_CHK_EN to add the err output (A>=q, B>=q or q==0).
module mod_sub_pipe
  import mod_arith_pkg::*;
#(
  parameter int BIT_SIZE = MOD_BIT_SIZE
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] A,
  input  logic [BIT_SIZE-1:0] B,
  input  logic [BIT_SIZE-1:0] q,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] M
`ifdef MOD_SUB_RANGE_CHK_EN
  ,
  output logic                err
`endif
);

  sub_s1_t             w_s1_d;
  sub_s1_t             w_s1_q;
  sub_s2_t             w_s2_d;
  sub_s2_t             w_s2_q;
  logic                w_s1_valid;
  logic                w_s2_ready;
  logic [BIT_SIZE:0]   w_diff;

  // Extra top bit of the difference is the borrow.
  always_comb begin
    w_diff        = {1'b0, A} - {1'b0, B};
    w_s1_d        = '0;
    w_s1_d.borrow = w_diff[BIT_SIZE];
    w_s1_d.diff   = w_diff[BIT_SIZE-1:0];
    w_s1_d.q      = q;
`ifdef MOD_SUB_RANGE_CHK_EN
    w_s1_d.err    = (A >= q) | (B >= q) | (q == '0);
`endif
  end

  mod_pipe_slice #(
    .W($bits(sub_s1_t))
  ) u_s1 (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_s1_d),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_q)
  );

  // Borrowed differences wrap back into range by adding q.
  always_comb begin
    w_s2_d   = '0;
    w_s2_d.m = w_s1_q.borrow ? (w_s1_q.diff + w_s1_q.q)
                             : w_s1_q.diff;
`ifdef MOD_SUB_RANGE_CHK_EN
    w_s2_d.err = w_s1_q.err;
`endif
  end

  mod_pipe_slice #(
    .W($bits(sub_s2_t))
  ) u_s2 (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  (w_s2_d),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_s2_q)
  );

  assign M = w_s2_q.m;
`ifdef MOD_SUB_RANGE_CHK_EN
  assign err = w_s2_q.err;
`endif

endmodule

// File: tb/tb_mod_sub_pipe.sv
// Directed self-checking bench for mod_sub_pipe.
// Checks err too when MOD_SUB_RANGE_CHK_EN is defined.
module tb_mod_sub_pipe;
  import mod_arith_pkg::*;

  localparam int W = 60;
  localparam logic [W-1:0] Q60 = 60'hFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] Q60M1 = 60'hFFF_FFFF_FFFF_FFFE;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] q = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] M;
`ifdef MOD_SUB_RANGE_CHK_EN
  logic         err;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mod_sub_pipe #(.BIT_SIZE(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .M         (M)
`ifdef MOD_SUB_RANGE_CHK_EN
    ,
    .err       (err)
`endif
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] m;
    logic         e;
    string        name;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // Single op, no backpressure: out_valid is a one-cycle pulse
  // appearing MOD_SUB_LATENCY edges after the op is presented.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk({v.name, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    q = v.q;
    A = v.a;
    B = v.b;
    for (int i = 1; i < MOD_SUB_LATENCY; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk({v.name, ".early"}, {63'd0, out_valid}, 64'd0);
    end
    @(negedge clk);
    chk({v.name, ".valid"}, {63'd0, out_valid}, 64'd1);
    chk({v.name, ".M"}, {4'd0, M}, {4'd0, v.m});
`ifdef MOD_SUB_RANGE_CHK_EN
    chk({v.name, ".err"}, {63'd0, err}, {63'd0, v.e});
`endif
    @(negedge clk);
    chk({v.name, ".pulse"}, {63'd0, out_valid}, 64'd0);
  endtask

  task automatic present(input logic [W-1:0] qq, input logic [W-1:0] aa,
                         input logic [W-1:0] bb);
    in_valid = 1'b1;
    q = qq;
    A = aa;
    B = bb;
  endtask

  initial begin
    vecs[0]  = '{60'd600000, 60'd512831, 60'd71923, 60'd440908, 1'b0, "basic"};
    vecs[1]  = '{60'd600000, 60'd71923, 60'd512831, 60'd159092, 1'b0, "borrow"};
    vecs[2]  = '{Q60, 60'd0, 60'd1, Q60M1, 1'b0, "wide_wrap"};
    vecs[3]  = '{Q60, Q60M1, Q60M1, 60'd0, 1'b0, "wide_eq"};
    vecs[4]  = '{60'd31238, 60'd8, 60'd3, 60'd5, 1'b0, "small"};
    vecs[5]  = '{60'd31238, 60'd3, 60'd8, 60'd31233, 1'b0, "small_b"};
    vecs[6]  = '{60'd31238, 60'd100, 60'd100, 60'd0, 1'b0, "a_eq_b"};
    vecs[7]  = '{60'd1000, 60'd777, 60'd0, 60'd777, 1'b0, "b_zero"};
    vecs[8]  = '{60'd1000, 60'd0, 60'd999, 60'd1, 1'b0, "a0_bqm1"};
    vecs[9]  = '{60'd600000, 60'd599999, 60'd0, 60'd599999, 1'b0, "max_a"};
    vecs[10] = '{60'd10, 60'd15, 60'd20, 60'd5, 1'b1, "ooc_borrow"};
    vecs[11] = '{60'd10, 60'd25, 60'd3, 60'd22, 1'b1, "ooc_plain"};
    vecs[12] = '{60'd31238, 60'd31238, 60'd3, 60'd31235, 1'b1, "a_eq_q"};
    vecs[13] = '{60'd0, 60'd5, 60'd3, 60'd2, 1'b1, "q_zero"};
    vecs[14] = '{60'd31238, 60'd8, 60'd31238, 60'd8, 1'b1, "b_eq_q"};

    #1;
    chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst.M", {4'd0, M}, 64'd0);
    chk("rst.in_ready", {63'd0, in_ready}, 64'd1);
`ifdef MOD_SUB_RANGE_CHK_EN
    chk("rst.err", {63'd0, err}, 64'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Back-to-back stream at full rate.
    @(negedge clk);
    present(60'd1000, 60'd10, 60'd3);
    @(negedge clk);
    present(60'd1000, 60'd3, 60'd10);
    chk("stream.v0", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    present(60'd1000, 60'd500, 60'd500);
    chk("stream.M0", {4'd0, M}, 64'd7);
    chk("stream.v1", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("stream.M1", {4'd0, M}, 64'd993);
    @(negedge clk);
    chk("stream.M2", {4'd0, M}, 64'd0);
    chk("stream.v2", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    chk("stream.end", {63'd0, out_valid}, 64'd0);

    // Backpressure: two ops fill the pipe, the third waits.
    out_ready = 1'b0;
    present(60'd31238, 60'd8, 60'd3);
    chk("bp.rdy0", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    present(60'd31238, 60'd3, 60'd8);
    chk("bp.rdy1", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    present(60'd31238, 60'd100, 60'd100);
    chk("bp.rdy2", {63'd0, in_ready}, 64'd0);
    chk("bp.M_a", {4'd0, M}, 64'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp.hold_M", {4'd0, M}, 64'd5);
      chk("bp.hold_v", {63'd0, out_valid}, 64'd1);
      chk("bp.hold_rdy", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.rel_rdy", {63'd0, in_ready}, 64'd1);
    chk("bp.rel_M0", {4'd0, M}, 64'd5);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp.rel_M1", {4'd0, M}, 64'd31233);
    chk("bp.rel_v1", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    chk("bp.rel_M2", {4'd0, M}, 64'd0);
    chk("bp.rel_v2", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    chk("bp.drain", {63'd0, out_valid}, 64'd0);

    // Reset with two ops in flight.
    out_ready = 1'b0;
    present(60'd31238, 60'd8, 60'd3);
    @(negedge clk);
    present(60'd31238, 60'd3, 60'd8);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mrst.pre_v", {63'd0, out_valid}, 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mrst.v", {63'd0, out_valid}, 64'd0);
    chk("mrst.M", {4'd0, M}, 64'd0);
    chk("mrst.rdy", {63'd0, in_ready}, 64'd1);
    present(60'd31238, 60'd9, 60'd1);
    @(negedge clk);
    chk("mrst.hold_v", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b0;
    rstn = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mrst.stale_v", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("mrst.stale_v2", {63'd0, out_valid}, 64'd0);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
